// File: rtl/song_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : song_reader_pkg
//  Description : Shared widths, sequencer state encoding, end-of-song marker
//                and the song ROM contents table for song_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package song_reader_pkg;

    localparam int NOTE_W = 6;                   // note code width, 0 = rest
    localparam int DUR_W  = 6;                   // duration in 1/48 s beats
    localparam int IDX_W  = 5;                   // note index within a song
    localparam int SONG_W = 2;                   // four songs in the ROM
    localparam int ROM_AW = SONG_W + IDX_W;      // {song, index}
    localparam int ROM_DW = NOTE_W + DUR_W;      // {note, duration}

    localparam logic [DUR_W-1:0] END_MARKER = '0;   // zero duration ends a song
    localparam logic [IDX_W-1:0] IDX_MAX    = '1;   // last index before wrap

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_ROM  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_END       = 3'd5
    } state_e;

    // Song ROM contents. Unlisted words of songs 0..2 read as zero, which is
    // the end marker. Song 3 fills every index (note = index+1, duration 1)
    // so that it only ends through the index wrap.
    function automatic logic [ROM_DW-1:0] rom_word(input logic [ROM_AW-1:0] addr);
        logic [ROM_DW-1:0] w;
        w = '0;
        case (addr)
            // song 0
            7'd0:    w = {6'd10, 6'd12};
            7'd1:    w = {6'd20, 6'd8};
            7'd2:    w = {6'd30, 6'd5};
            7'd3:    w = {6'd0,  6'd10};     // rest
            7'd4:    w = {6'd15, 6'd2};
            // song 1
            7'd32:   w = {6'd5,  6'd6};
            7'd33:   w = {6'd7,  6'd9};
            7'd34:   w = {6'd9,  6'd3};
            // song 2
            7'd64:   w = {6'd40, 6'd20};
            7'd65:   w = {6'd41, 6'd21};
            default: begin
                if (addr[ROM_AW-1 -: SONG_W] == SONG_W'(3)) begin
                    w = {NOTE_W'(addr[IDX_W-1:0]) + NOTE_W'(1), DUR_W'(1)};
                end
            end
        endcase
        return w;
    endfunction

endpackage : song_reader_pkg
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ============================================================================
//  Module      : song_rom
//  Description : 128 x 12 synchronous ROM holding four songs of 32 words,
//                word = {note[5:0], duration[5:0]}, one-cycle read latency.
//                Contents come from the rom_word table in song_reader_pkg.
//  Ports       : clk  - system clock
//                addr - {song, index} read address
//                dout - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module song_rom
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [ROM_DW-1:0] dout
);

    logic [ROM_DW-1:0] dout_q;

    always_ff @(posedge clk) begin
        dout_q <= rom_word(addr);
    end

    assign dout = dout_q;

endmodule : song_rom
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
//  Module      : song_reader
//  Description : Steps through the selected song in song_rom and hands one
//                (note, duration) pair at a time to the note player using the
//                new_note / note_done handshake. play pauses and resumes.
//                Build option SONG_LOOP_EN: restart the song at index 0
//                instead of parking in END when it finishes.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                play               - 1 = play/resume, 0 = pause in place
//                song               - song select
//                note_done          - level from the player, note finished
//                note_to_load       - registered note code for the player
//                duration_to_load   - registered duration for the player
//                new_note           - one-cycle load strobe
//                song_done          - one-cycle end-of-song strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module song_reader
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note_to_load,
    output logic [DUR_W-1:0]  duration_to_load,
    output logic              new_note,
    output logic              song_done
);

`ifdef SONG_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic                blank_q, blank_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                new_note_q, new_note_d;
    logic                song_done_q, song_done_d;

    logic [ROM_AW-1:0]   w_rom_addr;
    logic [ROM_DW-1:0]   w_rom_dout;
    logic [NOTE_W-1:0]   w_rom_note;
    logic [DUR_W-1:0]    w_rom_dur;
    logic                w_end_marker;
    logic                w_song_change;

    assign w_rom_addr   = {song_q, index_q};
    assign w_rom_note   = w_rom_dout[ROM_DW-1 -: NOTE_W];
    assign w_rom_dur    = w_rom_dout[DUR_W-1:0];
    assign w_end_marker = (w_rom_dur == END_MARKER);

    // IDLE latches the song on its own; END ignores the selector until the
    // block has gone back through IDLE.
    assign w_song_change = (song != song_q) &&
                           (state_q != ST_IDLE) && (state_q != ST_END);

    song_rom u_song_rom (
        .clk  (clk),
        .addr (w_rom_addr),
        .dout (w_rom_dout)
    );

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        song_d      = song_q;
        blank_d     = blank_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        if (w_song_change) begin
            // Restart on the new song; this outranks a note_done in the same
            // cycle and is honoured even while paused.
            song_d  = song;
            index_d = '0;
            blank_d = 1'b0;
            state_d = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        song_d  = song;
                        index_d = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (play) begin
                        state_d = ST_WAIT_ROM;
                    end
                end
                ST_WAIT_ROM: begin
                    // ROM data is already valid here, so the strobes are
                    // registered on the way into ISSUE and appear during it.
                    if (play) begin
                        state_d = ST_ISSUE;
                        if (w_end_marker) begin
                            song_done_d = 1'b1;
                        end else begin
                            new_note_d = 1'b1;
                            note_d     = w_rom_note;
                            dur_d      = w_rom_dur;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (play) begin
                        if (w_end_marker) begin
                            if (LOOP_EN) begin
                                index_d = '0;
                                state_d = ST_FETCH;
                            end else begin
                                state_d = ST_END;
                            end
                        end else begin
                            blank_d = 1'b1;
                            state_d = ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    // The first cycle after a load is blanked: the player may
                    // still be showing done for the previous note.
                    if (play) begin
                        blank_d = 1'b0;
                        if (!blank_q && note_done) begin
                            if (index_q == IDX_MAX) begin
                                song_done_d = 1'b1;
                                index_d     = '0;
                                if (LOOP_EN) begin
                                    state_d = ST_FETCH;
                                end else begin
                                    state_d = ST_END;
                                end
                            end else begin
                                index_d = index_q + IDX_W'(1);
                                state_d = ST_FETCH;
                            end
                        end
                    end
                end
                ST_END: begin
                    if (!play) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            song_q      <= '0;
            blank_q     <= 1'b0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            song_q      <= song_d;
            blank_q     <= blank_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign new_note         = new_note_q;
    assign song_done        = song_done_q;

endmodule : song_reader
`default_nettype wire

// File: tb/tb_song_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_song_reader
//  Description : Scoreboard bench for song_reader. Stimulus pushes expected
//                (note, duration, cycle) or (song_done, cycle) entries; a
//                monitor pops one entry per strobe. A note-player model holds
//                note_done high from 5 cycles after each new_note until the
//                next load. Define SONG_LOOP_EN to exercise the looping build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_song_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note_to_load;
    logic [5:0] duration_to_load;
    logic       new_note;
    logic       song_done;

    always #5 clk = ~clk;

    song_reader dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .note_done        (note_done),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .new_note         (new_note),
        .song_done        (song_done)
    );

    typedef struct {
        bit       is_done;
        int       note;
        int       dur;
        int       cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   pcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Note player model
    initial begin
        note_done = 1'b0;
        forever begin
            @(negedge clk);
            if (new_note) pcnt = 1;
            else if (pcnt != 0 && pcnt < 6) pcnt = pcnt + 1;
            note_done = (pcnt >= 6);
        end
    end

    // Monitor: one scoreboard entry per strobe
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (new_note || song_done)) begin
                n_checks++;
                if (new_note && song_done) begin
                    n_fails++;
                    $display("FAIL strobe_overlap: new_note=1 song_done=1 at cycle %0d, expected at most one", cyc);
                end else if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_strobe: new_note=%0d song_done=%0d at cycle %0d, expected none",
                             new_note, song_done, cyc);
                end else begin
                    e = sb.pop_front();
                    if ((int'(song_done) != int'(e.is_done)) || (cyc != e.cyc) ||
                        (!e.is_done && ((int'(note_to_load) != e.note) ||
                                        (int'(duration_to_load) != e.dur)))) begin
                        n_fails++;
                        $display("FAIL strobe: got done=%0d note=%0d dur=%0d cyc=%0d, expected done=%0d note=%0d dur=%0d cyc=%0d",
                                 song_done, note_to_load, duration_to_load, cyc,
                                 e.is_done, e.note, e.dur, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push_note(input int n, input int d, input int c);
        exp_t x;
        x.is_done = 1'b0; x.note = n; x.dur = d; x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic push_done(input int c);
        exp_t x;
        x.is_done = 1'b1; x.note = 0; x.dur = 0; x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain_timeout: %0d strobes outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        play  = 1'b0;
        song  = 2'd0;
        tick(2);
        check("rst_note", int'(note_to_load), 0);
        check("rst_dur", int'(duration_to_load), 0);
        check("rst_new_note", int'(new_note), 0);
        check("rst_song_done", int'(song_done), 0);
        reset = 1'b0;
        tick(1);
    endtask

    int p, n2, m, w;

    initial begin
        reset = 1'b1;
        play  = 1'b0;
        song  = 2'd0;
        do_reset();

        // Song 0: first notes, pause with note_done high, then song change
        song = 2'd0;
        play = 1'b1;
        p = cyc;
        push_note(10, 12, p + 3);
        push_note(20, 8,  p + 11);
        push_note(30, 5,  p + 19);
        n2 = p + 19;
        wait_cycle(n2 + 5);
        play = 1'b0;
        wait_cycle(n2 + 11);
        play = 1'b1;
        push_note(0, 10, n2 + 14);
        m = n2 + 14;
        wait_cycle(m + 5);
        song = 2'd2;
        push_note(40, 20, m + 8);
        push_note(41, 21, m + 16);
        push_done(m + 24);
`ifdef SONG_LOOP_EN
        push_note(40, 20, m + 27);
`endif
        drain(80);
        tick(2);
`ifndef SONG_LOOP_EN
        check("end_note_hold", int'(note_to_load), 41);
        check("end_dur_hold", int'(duration_to_load), 21);
`endif
        do_reset();

`ifndef SONG_LOOP_EN
        // Song 1: three notes, end marker, park in END, back through IDLE
        song = 2'd1;
        play = 1'b1;
        p = cyc;
        push_note(5, 6, p + 3);
        push_note(7, 9, p + 11);
        push_note(9, 3, p + 19);
        push_done(p + 27);
        drain(80);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("park_note", int'(note_to_load), 9);
            check("park_dur", int'(duration_to_load), 3);
        end
        play = 1'b0;
        p = cyc;
        tick(2);
        play = 1'b1;
        push_note(5, 6, p + 5);
        drain(20);
        do_reset();
`endif

        // Song 3: all 32 indices, end of song by index wrap
        song = 2'd3;
        play = 1'b1;
        p = cyc;
        for (int i = 0; i < 32; i++) begin
            push_note(i + 1, 1, p + 3 + 8 * i);
        end
        w = p + 3 + 8 * 31 + 6;
        push_done(w);
`ifdef SONG_LOOP_EN
        push_note(1, 1, w + 2);
`endif
        drain(400);
        tick(2);
        do_reset();

`ifdef SONG_LOOP_EN
        // Song 2 (two notes) loops straight back to its first note
        song = 2'd2;
        play = 1'b1;
        p = cyc;
        push_note(40, 20, p + 3);
        push_note(41, 21, p + 11);
        push_done(p + 19);
        push_note(40, 20, p + 22);
        drain(60);
        tick(2);
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_song_reader
`default_nettype wire
